alu_exec_unit: RTL

Parametrised successor to the single-cycle ALU control decode. It combines funct3/funct7/op5 decode with a registered execute stage. Base RV32I/RV64I operations complete in one cycle. Optional M-extension multiply/divide/remainder operations run on an iterative multi-cycle datapath behind a valid/ready handshake. It sits in the execute stage and stalls the pipeline through ready_out while a multi-cycle operation is in flight.

---
 rtl/alu_exec_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU decode plus registered execute stage with iterative multi-cycle M-extension datapath
module alu_exec_unit #(
  parameter int XLEN   = 32,
  parameter bit MDU_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic            flush,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic            op5,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            valid_out
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  typedef enum logic [3:0] {OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND} op_t;
  state_t state_q, state_d;
  op_t op;
  logic is_m;
  logic [XLEN-1:0] alu_res;
  logic [SW-1:0] shamt;
  logic [2:0] op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] mb_q, mb_d;
  logic [2*XLEN-1:0] p_q, p_d, p_step, prod;
  logic neg_q, neg_d, div0_q, div0_d;
  logic [XLEN-1:0] result_q, result_d;
  logic zero_q, zero_d, valid_q, valid_d;
  logic sa_en, sb_en, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b, quo, rem, fix_res;
  logic [XLEN:0] mul_sum, div_sh, div_diff;
  logic div_ge;
  always_comb begin
    op = OP_ADD;
    is_m = 1'b0;
    if (alu_op == 2'b01)
      op = (funct3[2:1] == 2'b00) ? OP_SUB : (funct3[2:1] == 2'b10) ? OP_SLT : (funct3[2:1] == 2'b11) ? OP_SLTU : OP_ADD;
    else if (alu_op == 2'b10) begin
      is_m = MDU_EN && op5 && funct7_0;
      case (funct3)
        3'b000:  op = (op5 && funct7_5) ? OP_SUB : OP_ADD;
        3'b001:  op = OP_SLL;
        3'b010:  op = OP_SLT;
        3'b011:  op = OP_SLTU;
        3'b100:  op = OP_XOR;
        3'b101:  op = funct7_5 ? OP_SRA : OP_SRL;
        3'b110:  op = OP_OR;
        default: op = OP_AND;
      endcase
    end
  end
  assign shamt = src_b[SW-1:0];
  always_comb begin
    case (op)
      OP_SUB:  alu_res = src_a - src_b;
      OP_SLL:  alu_res = src_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SRL:  alu_res = src_a >> shamt;
      OP_SRA:  alu_res = $signed(src_a) >>> shamt;
      OP_OR:   alu_res = src_a | src_b;
      OP_AND:  alu_res = src_a & src_b;
      default: alu_res = src_a + src_b;
    endcase
  end
  // Signedness per M-op: MUL/MULH/DIV/REM both signed, MULHSU only A.
  assign sa_en = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
  assign sb_en = funct3[2] ? !funct3[0] : !funct3[1];
  assign a_neg = sa_en & src_a[XLEN-1];
  assign b_neg = sb_en & src_b[XLEN-1];
  assign mag_a = a_neg ? -src_a : src_a;
  assign mag_b = b_neg ? -src_b : src_b;
  // One shift-add (multiply) or restoring-subtract (divide) step on {hi, lo}.
  assign mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, mb_q} : {(XLEN+1){1'b0}});
  assign div_sh   = p_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_sh - {1'b0, mb_q};
  assign div_ge   = !div_diff[XLEN];
  assign p_step   = op_q[2] ? {div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0], p_q[XLEN-2:0], div_ge}
                            : {mul_sum, p_q[XLEN-1:1]};
  assign prod = neg_q ? -p_q : p_q;
  assign quo  = p_q[XLEN-1:0];
  assign rem  = p_q[2*XLEN-1:XLEN];
  // Divide-by-zero remainder falls out naturally as the signed dividend; only the quotient needs forcing.
  assign fix_res = !op_q[2] ? ((op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                 : op_q[1]  ? (neg_q ? -rem : rem)
                 : div0_q   ? {XLEN{1'b1}} : (neg_q ? -quo : quo);
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    mb_d     = mb_q;
    p_d      = p_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    result_d = result_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    if (flush)
      state_d = IDLE;
    else
      case (state_q)
        IDLE: if (valid_in) begin
          if (is_m) begin
            state_d = RUN;
            op_d    = funct3;
            cnt_d   = '0;
            mb_d    = mag_b;
            p_d     = {{XLEN{1'b0}}, mag_a};
            neg_d   = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
            div0_d  = (src_b == '0);
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            valid_d  = 1'b1;
          end
        end
        RUN: begin
          p_d     = p_step;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == CW'(XLEN-1)) ? FIX : RUN;
        end
        default: begin
          result_d = fix_res;
          zero_d   = (fix_res == '0);
          valid_d  = 1'b1;
          state_d  = IDLE;
        end
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      mb_q     <= '0;
      p_q      <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      mb_q     <= mb_d;
      p_q      <= p_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end
  assign ready_out = (state_q == IDLE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign valid_out = valid_q;
endmodule
